// File: rtl/io_map_pkg.sv
// I/O-space address map shared by the switch input port and the output-port decode.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package io_map_pkg;

    // Board switch count and the width of each presented input port.
    localparam int NUM_SW = 16;
    localparam int PORT_W = 8;

    // Word offsets decoded from addr[7:2].
    localparam logic [5:0] IO_IN0 = 6'h30;
    localparam logic [5:0] IO_IN1 = 6'h31;
    localparam logic [5:0] IO_CHG = 6'h32;
    localparam logic [5:0] IO_RAW = 6'h33;

    // Which register a read selects; SEL_NONE reads back as zero.
    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_IN0  = 3'd1,
        SEL_IN1  = 3'd2,
        SEL_CHG  = 3'd3,
        SEL_RAW  = 3'd4
    } io_sel_e;

    // Map a word offset onto a register select.
    function automatic io_sel_e io_decode(input logic [5:0] off);
        io_sel_e sel;
        case (off)
            IO_IN0:  sel = SEL_IN0;
            IO_IN1:  sel = SEL_IN1;
            IO_CHG:  sel = SEL_CHG;
            IO_RAW:  sel = SEL_RAW;
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    // Zero-extend a byte onto the 32-bit data bus.
    function automatic logic [31:0] zext8(input logic [7:0] v);
        return {24'b0, v};
    endfunction

    // Zero-extend a half-word onto the 32-bit data bus.
    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'b0, v};
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchronizer, stability counter and accepted level.
// Latency: 2 + DEBOUNCE_CYCLES clocks from a held pin level to stable.
// Backpressure: none; toggle is a single-cycle pulse on the accepting edge.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic stable,
    output logic toggle
);

    // Count value reached on the edge that accepts the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;
    logic             differs;
    logic             accept;

    // Synchronized level disagrees with the accepted one.
    assign differs = sync_q2 ^ stable;

    // Enough consecutive disagreeing cycles have been seen: accept on this edge.
    assign accept = differs && (cnt == CNT_LAST);

    // The toggle pulse lines up with the stable update so flags set on the same edge.
    assign toggle = accept;

    // Two-stage synchronizer for the asynchronous pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= pin;
            sync_q2 <= sync_q1;
        end
    end

    // Count disagreeing cycles; any agreement restarts, acceptance also restarts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (!differs) begin
            cnt <= '0;
        end else if (accept) begin
            stable <= sync_q2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sw_in_port_ctrl.sv
// Debounced board switches presented as memory-mapped input ports with read-to-clear edge flags.
// Latency: pin to stable 2 + DEBOUNCE_CYCLES clocks; rdata combinational from addr.
// Backpressure: none; every read completes in the cycle addr is presented.
module sw_in_port_ctrl
    import io_map_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sw,
    input  logic [31:0] addr,
    input  logic        rd,
    output logic [31:0] rdata,
    output logic [31:0] in_port0,
    output logic [31:0] in_port1,
    output logic        irq
);

    logic [NUM_SW-1:0] stable;
    logic [NUM_SW-1:0] toggle;
    logic [NUM_SW-1:0] chg;
    io_sel_e           sel;
    logic              chg_clr;

    // Only addr[7:2] takes part in the decode; the remaining bits are don't-care.
    logic addr_unused;
    assign addr_unused = ^{addr[31:8], addr[1:0]};

    // One debouncer per switch; each reports its own acceptance pulse.
    for (genvar g = 0; g < NUM_SW; g++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .pin    (sw[g]),
            .stable (stable[g]),
            .toggle (toggle[g])
        );
    end

    assign sel      = io_decode(addr[7:2]);
    assign chg_clr  = rd && (sel == SEL_CHG);
    assign in_port0 = zext8(stable[PORT_W-1:0]);
    assign in_port1 = zext8(stable[NUM_SW-1:PORT_W]);
    assign irq      = |chg;

    // Change flags: a read of the flag register clears, a same-edge toggle keeps its bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chg <= '0;
        end else begin
            chg <= (chg & ~{NUM_SW{chg_clr}}) | toggle;
        end
    end

    // Read mux; the flag register shows its pre-clear value during the clearing read.
    always_comb begin
        rdata = '0;
        case (sel)
            SEL_IN0:  rdata = in_port0;
            SEL_IN1:  rdata = in_port1;
            SEL_CHG:  rdata = zext16(chg);
            SEL_RAW:  rdata = zext16(stable);
            default:  rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_sw_in_port_ctrl.sv
// Directed scenarios followed by randomized traffic, checked against a window-based switch model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sw_in_port_ctrl;

    localparam int DEB = 4;

    logic        clk;
    logic        reset;
    logic [15:0] sw;
    logic [31:0] addr;
    logic        rd;
    logic [31:0] rdata;
    logic [31:0] in_port0;
    logic [31:0] in_port1;
    logic        irq;

    int n_checks = 0;
    int n_errs   = 0;

    // Model state: pins sampled at each edge since reset, accepted levels, flags.
    logic [15:0] pin_hist[$];
    logic [15:0] m_stable;
    logic [15:0] m_chg;

    sw_in_port_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .addr     (addr),
        .rd       (rd),
        .rdata    (rdata),
        .in_port0 (in_port0),
        .in_port1 (in_port1),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        pin_hist.delete();
        m_stable = '0;
        m_chg    = '0;
    endtask

    // Level seen by the debouncer at the current edge, j edges back: the pin two edges earlier.
    function automatic logic [15:0] synced(input int j);
        int idx;
        idx = pin_hist.size() - 2 - j;
        return (idx >= 0) ? pin_hist[idx] : 16'h0;
    endfunction

    // A bit is accepted once its synchronized level has opposed stable for DEB edges in a row.
    task automatic model_edge(input logic [15:0] pins, input logic clr, input logic rst_s);
        logic [15:0] tog;
        if (rst_s) begin
            m_reset();
            return;
        end
        tog = '0;
        for (int i = 0; i < 16; i++) begin
            logic all_new;
            all_new = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                logic [15:0] s;
                s = synced(j);
                if (s[i] == m_stable[i]) all_new = 1'b0;
            end
            tog[i] = all_new;
        end
        m_stable = m_stable ^ tog;
        m_chg    = (clr ? 16'h0 : m_chg) | tog;
        pin_hist.push_back(pins);
        if (pin_hist.size() > DEB + 2) void'(pin_hist.pop_front());
    endtask

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        logic [5:0] off;
        off = a[7:2];
        case (off)
            6'h30:   return {24'h0, m_stable[7:0]};
            6'h31:   return {24'h0, m_stable[15:8]};
            6'h32:   return {16'h0, m_chg};
            6'h33:   return {16'h0, m_stable};
            default: return 32'h0;
        endcase
    endfunction

    // Advance one clock: capture pre-edge inputs for the model, then settle 1 time unit past the edge.
    task automatic step();
        logic [15:0] sw_s;
        logic        clr_s;
        logic        rst_s;
        sw_s  = sw;
        clr_s = rd && (addr[7:2] == 6'h32);
        rst_s = reset;
        @(posedge clk);
        model_edge(sw_s, clr_s, rst_s);
        #1;
    endtask

    task automatic rd_at(input logic [7:0] off, input string tag, input logic [31:0] exp);
        addr = {24'h0, off};
        #1;
        chk(tag, rdata, exp);
    endtask

    initial begin
        logic [31:0] r;
        logic [5:0]  sel;

        // Reset with every pin high.
        reset = 1'b1; sw = 16'hFFFF; addr = '0; rd = 1'b0;
        m_reset();
        #2;
        rd_at(8'hC0, "rst_in0", 32'h0);
        rd_at(8'hC4, "rst_in1", 32'h0);
        rd_at(8'hC8, "rst_chg", 32'h0);
        rd_at(8'hCC, "rst_raw", 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        step(); step();
        chk("rst_hold_in1", in_port1, 32'h0);

        // Clean edge: accepted exactly 2 + DEB edges after the pin change.
        reset = 1'b0; sw = 16'h0081; addr = 32'hC0;
        repeat (5) step();
        chk("clean_early", in_port0, 32'h0);
        step();
        chk("clean_lat", in_port0, 32'h81);
        rd_at(8'hC8, "clean_chg", 32'h0081);
        chk("clean_irq", {31'h0, irq}, 32'h1);

        // Three-cycle glitch on sw[3] is rejected.
        sw = 16'h0089; repeat (3) step();
        sw = 16'h0081; repeat (8) step();
        rd_at(8'hCC, "glitch_raw", 32'h0081);
        rd_at(8'hC8, "glitch_chg", 32'h0081);

        // Reads of other registers never clear.
        addr = 32'hC0; rd = 1'b1; repeat (2) step();
        rd = 1'b0;
        rd_at(8'hC8, "noclr_chg", 32'h0081);

        // Read-to-clear: pre-clear value, then zero.
        rd = 1'b1;
        rd_at(8'hC8, "clr_first", 32'h0081);
        step();
        chk("clr_second", rdata, 32'h0);
        rd = 1'b0;
        #1;
        chk("clr_irq", {31'h0, irq}, 32'h0);

        // Four-cycle hold on sw[3] is accepted, and so is its return.
        sw = 16'h0089; repeat (4) step();
        sw = 16'h0081; step(); step();
        rd_at(8'hCC, "hold_raw", 32'h0089);
        repeat (6) step();
        rd_at(8'hCC, "hold_back", 32'h0081);
        rd_at(8'hC8, "hold_chg", 32'h0008);

        // sw[9] accepted on the same edge as the clearing read: set wins.
        sw = 16'h0281; repeat (5) step();
        rd = 1'b1;
        rd_at(8'hC8, "coll_old", 32'h0008);
        step();
        rd = 1'b0;
        #1;
        chk("coll_new", rdata, 32'h0200);
        rd_at(8'hCC, "coll_raw", 32'h0281);
        chk("coll_irq", {31'h0, irq}, 32'h1);

        // Reset in the middle of a debounce.
        sw = 16'hFF00; repeat (3) step();
        reset = 1'b1; m_reset();
        #1;
        chk("mid_rst_in1", in_port1, 32'h0);
        rd_at(8'hC8, "mid_rst_chg", 32'h0);
        step(); step();
        reset = 1'b0;
        repeat (5) step();
        chk("mid_early", in_port1, 32'h0);
        step();
        chk("mid_lat", in_port1, 32'hFF);
        chk("mid_in0", in_port0, 32'h0);
        rd_at(8'hC8, "mid_chg", 32'hFF00);

        // Randomized traffic against the model.
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 3) == 0)
                sw = sw ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            r = $urandom;
            if (r[2:0] == 3'd7) sel = r[8:3];
            else                sel = 6'h30 + {4'h0, r[4:3]};
            r = $urandom;
            addr = {r[31:8], sel, r[1:0]};
            rd = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                m_reset();
            end else begin
                reset = 1'b0;
            end
            #1;
            chk("rnd_rdata", rdata, exp_rdata(addr));
            chk("rnd_in0", in_port0, {24'h0, m_stable[7:0]});
            chk("rnd_in1", in_port1, {24'h0, m_stable[15:8]});
            chk("rnd_irq", {31'h0, irq}, {31'h0, |m_chg});
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/sw_in_port_ctrl.md
# sw_in_port_ctrl

Memory-mapped switch input port for the single-cycle CPU's I/O space. Synchronizes and debounces the 16 board switches, then presents them as two 8-bit input ports. A read-to-clear change-flag register lets software poll for switch edges instead of re-comparing values. It is the input-side counterpart of the seven-segment output ports and sits between the board pins and the data-memory read mux.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required to accept a new switch level (5 ms at 50 MHz); legal range ≥ 1.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width.
- `clk`  in  1  system clock (same clock as the CPU I/O space).
- `reset`  in  1  asynchronous, active-high reset.
- `sw`  in  16  raw switch pins; `sw[7:0]` = SW1..SW8, `sw[15:8]` = SW9..SW16.
- `addr`  in  32  CPU data address.
- `rd`  in  1  CPU read strobe for the I/O space.
- `rdata`  out  32  read data; combinational from `addr`.
- `in_port0`  out  32  `{24'b0, stable[7:0]}`.
- `in_port1`  out  32  `{24'b0, stable[15:8]}`.
- `irq`  out  1  high while any change flag is set.

## Operation
- **Synchronizer**
  - Two flops per bit: `sync = sw` delayed two clocks.
  - Reset value: 0.
- **Debounce, per bit**
  - Holds `stable` (reset 0) and `cnt` (reset 0).
  - If `sync == stable`: `cnt <= 0`.
  - Otherwise `cnt <= cnt+1`. When `cnt == DEBOUNCE_CYCLES-1` on that edge, `stable <= sync` and `cnt <= 0`.
  - Any single-cycle return to `stable` restarts the count. Glitches shorter than `DEBOUNCE_CYCLES` cycles are never accepted.
- **Change flags**
  - `chg[15:0]`, reset 0.
  - Bit i sets on the edge where `stable[i]` toggles.
- **Register map**
  - Decode on `addr[7:2]`; `addr[1:0]` and `addr[31:8]` are ignored.
  - 0xC0: `in_port0`.
  - 0xC4: `in_port1`.
  - 0xC8: `{16'b0, chg}`.
  - 0xCC: `{16'b0, stable}`.
  - Any other offset returns 0.
- **Read-to-clear**
  - At the clock edge where `rd=1` and the address is 0xC8, `chg` is cleared.
  - `rdata` in that cycle shows the pre-clear value.
  - A toggle on the same edge as the clear leaves that bit set: set wins per bit.
  - Reads of other addresses have no side effect. `rd=0` never clears.
- `irq = |chg`, combinational from the flag register.

## Timing
- Pin-to-`stable` latency: 2 (sync) + `DEBOUNCE_CYCLES` cycles after the first edge where the pin holds its new level.
- `stable` and `chg` update on the same edge.
- `rdata` is combinational: valid in the cycle `addr` is applied, so the single-cycle CPU samples it at its load write-back edge.
- `irq` rises one edge after the toggle and falls one edge after the clearing read.
- Reset asserted mid-debounce: counters, sync flops, `stable` and `chg` return to 0 immediately.
  - After release, a switch held high is accepted after 2 + `DEBOUNCE_CYCLES` cycles and sets its flag. The first toggle out of reset is reported.
- Counter never wraps: it resets to 0 on acceptance or on a match, and `CNT_W` covers `DEBOUNCE_CYCLES`.

## Structure
- Package `io_map_pkg` holds:
  - address offsets `IO_IN0=6'h30`, `IO_IN1=6'h31`, `IO_CHG=6'h32`, `IO_RAW=6'h33`;
  - switch count `NUM_SW=16`.
- The output-port decode uses the same package.
- One sub-module, `debounce_bit`: 2-flop sync, counter and `stable` flop, plus a 1-cycle `toggle` pulse output.
  - Instantiated 16× in a generate loop.
  - The top level holds `chg`, the decode and the read-to-clear logic.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- **Reset:** assert `reset` with `sw=16'hFFFF`. Required: `rdata=0` at 0xC0, 0xC4, 0xC8 and 0xCC; `irq=0`.
- **Clean edge:** release reset, set `sw=16'h0081`, hold. Required: `in_port0` reads 0x81 exactly 6 cycles after the pin change; `chg` reads 0x0081; `irq=1`.
- **Glitch:** pulse `sw[3]` high for 3 cycles, then low. Required: `stable` and `chg` stay 0. A 4-cycle hold is accepted.
- **Read-to-clear:** read 0xC8. Required: returns 0x0081, and the next read returns 0. Reads of 0xC0 never clear.
- **Set-vs-clear collision:** arrange a `sw[9]` acceptance on the same edge as a 0xC8 read. Required: that read returns the old flags; `chg[9]` remains 1 afterwards.
- **Mid-debounce reset:** set `sw=16'hFF00`, assert reset 3 cycles later, release. Required: `in_port1` reads 0xFF only 6 cycles after release; `chg=16'hFF00`.
